// File: rtl/ciclo_bus_rtc_if.sv
// Multiplexed RTC bus bundle between the control side and ciclo_bus_rtc.
// master = command/RTC side, slave = bus-cycle generator.
interface ciclo_bus_rtc_if;
  logic       sync;
  logic [1:0] Control;
  logic [7:0] dir;
  logic [7:0] dato_esc;
  logic [7:0] ad_in;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       A_D;
  logic [7:0] dato_leido;
  logic       ocupado;
  logic       listo;
  logic       err_ocupado;

  modport master (
    output sync, Control, dir, dato_esc, ad_in,
    input  ad_out, ad_oe, CS_n, RD_n, WR_n, A_D,
    input  dato_leido, ocupado, listo, err_ocupado
  );

  modport slave (
    input  sync, Control, dir, dato_esc, ad_in,
    output ad_out, ad_oe, CS_n, RD_n, WR_n, A_D,
    output dato_leido, ocupado, listo, err_ocupado
  );
endinterface

// File: rtl/ciclo_bus_rtc.sv
// RTC bus-cycle generator: address phase then data phase per command.
// Optional busy-request flag enabled by defining RTC_BUS_ERR_EN.
module ciclo_bus_rtc #(
  parameter int T_SET   = 2,
  parameter int T_PULSO = 8,
  parameter int T_HOLD  = 2
) (
  input  logic           reloj,
  input  logic           resetM,
  ciclo_bus_rtc_if.slave bus
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] DIR_SET   = 3'd1;
  localparam logic [2:0] DIR_PULSO = 3'd2;
  localparam logic [2:0] DIR_HOLD  = 3'd3;
  localparam logic [2:0] DAT_SET   = 3'd4;
  localparam logic [2:0] DAT_PULSO = 3'd5;
  localparam logic [2:0] DAT_HOLD  = 3'd6;
  localparam logic [2:0] FIN       = 3'd7;

  localparam int TM1 = (T_SET > T_HOLD) ? T_SET : T_HOLD;
  localparam int TMAX = (T_PULSO > TM1) ? T_PULSO : TM1;
  localparam int CW = $clog2(TMAX + 1);

  localparam logic [CW-1:0] C_SET   = CW'(T_SET - 1);
  localparam logic [CW-1:0] C_PULSO = CW'(T_PULSO - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(T_HOLD - 1);

  logic [2:0]    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          done;
  logic          op_wr, op_n;
  logic [7:0]    dir_q, dir_n;
  logic [7:0]    dat_q, dat_n;
  logic          req_ok, start;

  logic          cs_q, rd_q, wr_q, ad_q, oe_q, ocup_q, listo_q;
  logic          cs_d, rd_d, wr_d, ad_d, oe_d, ocup_d, listo_d;
  logic [7:0]    out_q, out_d;
  logic [7:0]    leido_q;
  logic          ld_rd;
  logic          in_dir, in_dat;

  assign req_ok = bus.sync &&
                  (bus.Control == 2'b01 || bus.Control == 2'b10);
  assign start  = req_ok && (state == IDLE);
  assign done   = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = done ? cnt : cnt - CW'(1);
    unique case (state)
      IDLE: if (start) begin
        state_n = DIR_SET;
        cnt_n   = C_SET;
      end
      DIR_SET: if (done) begin
        state_n = DIR_PULSO;
        cnt_n   = C_PULSO;
      end
      DIR_PULSO: if (done) begin
        state_n = DIR_HOLD;
        cnt_n   = C_HOLD;
      end
      DIR_HOLD: if (done) begin
        state_n = DAT_SET;
        cnt_n   = C_SET;
      end
      DAT_SET: if (done) begin
        state_n = DAT_PULSO;
        cnt_n   = C_PULSO;
      end
      DAT_PULSO: if (done) begin
        state_n = DAT_HOLD;
        cnt_n   = C_HOLD;
      end
      DAT_HOLD: if (done) state_n = FIN;
      default: state_n = IDLE;
    endcase
  end

  // Command is captured on the start edge so outputs can use it at once.
  assign op_n  = start ? (bus.Control == 2'b10) : op_wr;
  assign dir_n = start ? bus.dir : dir_q;
  assign dat_n = start ? bus.dato_esc : dat_q;

  assign in_dir = (state_n == DIR_SET) || (state_n == DIR_PULSO) ||
                  (state_n == DIR_HOLD);
  assign in_dat = (state_n == DAT_SET) || (state_n == DAT_PULSO) ||
                  (state_n == DAT_HOLD);

  // Outputs are decoded from the next state and registered.
  always_comb begin
    cs_d    = 1'b1;
    rd_d    = 1'b1;
    wr_d    = 1'b1;
    ad_d    = ad_q;
    oe_d    = 1'b0;
    out_d   = out_q;
    ocup_d  = 1'b1;
    listo_d = 1'b0;
    unique case (1'b1)
      in_dir: begin
        cs_d  = 1'b0;
        ad_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = dir_n;
        wr_d  = (state_n != DIR_PULSO);
      end
      in_dat: begin
        cs_d  = 1'b0;
        ad_d  = 1'b1;
        oe_d  = op_n;
        out_d = op_n ? dat_n : dir_n;
        wr_d  = !(op_n && state_n == DAT_PULSO);
        rd_d  = !(!op_n && state_n == DAT_PULSO);
      end
      (state_n == FIN): listo_d = 1'b1;
      default: ocup_d = 1'b0;
    endcase
  end

  assign ld_rd = (state == DAT_PULSO) && done && !op_wr;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) begin
      state   <= IDLE;
      cnt     <= '0;
      op_wr   <= 1'b0;
      dir_q   <= 8'h00;
      dat_q   <= 8'h00;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      ad_q    <= 1'b0;
      oe_q    <= 1'b0;
      out_q   <= 8'h00;
      ocup_q  <= 1'b0;
      listo_q <= 1'b0;
      leido_q <= 8'h00;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      op_wr   <= op_n;
      dir_q   <= dir_n;
      dat_q   <= dat_n;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ad_q    <= ad_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      ocup_q  <= ocup_d;
      listo_q <= listo_d;
      if (ld_rd) leido_q <= bus.ad_in;
    end
  end

`ifdef RTC_BUS_ERR_EN
  logic err_q;

  always_ff @(posedge reloj or negedge resetM) begin
    if (!resetM) err_q <= 1'b0;
    else         err_q <= req_ok && (state != IDLE);
  end

  assign bus.err_ocupado = err_q;
`else
  assign bus.err_ocupado = 1'b0;
`endif

  assign bus.CS_n       = cs_q;
  assign bus.RD_n       = rd_q;
  assign bus.WR_n       = wr_q;
  assign bus.A_D        = ad_q;
  assign bus.ad_oe      = oe_q;
  assign bus.ad_out     = out_q;
  assign bus.ocupado    = ocup_q;
  assign bus.listo      = listo_q;
  assign bus.dato_leido = leido_q;

endmodule

// File: tb/tb_ciclo_bus_rtc.sv
// Directed bench for ciclo_bus_rtc: read, write, busy, reset, b2b.
// Expectations depend on RTC_BUS_ERR_EN when it is defined.
module tb_ciclo_bus_rtc;

  logic reloj = 1'b0;
  logic resetM = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef RTC_BUS_ERR_EN
  localparam int EXP_ERR   = 2;
  localparam int EXP_ERR_J = 6;
`else
  localparam int EXP_ERR   = 0;
  localparam int EXP_ERR_J = 0;
`endif

  ciclo_bus_rtc_if bus();

  ciclo_bus_rtc #(
    .T_SET(2),
    .T_PULSO(8),
    .T_HOLD(2)
  ) dut (
    .reloj (reloj),
    .resetM(resetM),
    .bus   (bus)
  );

  always #5 reloj = ~reloj;

  // Returns at the falling edge of cycle k+1 (sync sampled at edge k).
  task automatic kick(input logic [1:0] c, input logic [7:0] d,
                      input logic [7:0] w);
    @(negedge reloj);
    bus.sync = 1'b1;
    bus.Control = c;
    bus.dir = d;
    bus.dato_esc = w;
    @(negedge reloj);
    bus.sync = 1'b0;
  endtask

  task automatic test_reset();
    resetM = 1'b0;
    bus.sync = 1'b0;
    bus.Control = 2'b00;
    bus.dir = 8'h00;
    bus.dato_esc = 8'h00;
    bus.ad_in = 8'h00;
    repeat (3) @(negedge reloj);
    n_cmp++;
    if ({bus.CS_n, bus.RD_n, bus.WR_n, bus.A_D, bus.ad_oe} !== 5'b11100) begin
      n_bad++;
      $display("FAIL reset_strobes got %b want 11100",
               {bus.CS_n, bus.RD_n, bus.WR_n, bus.A_D, bus.ad_oe});
    end
    n_cmp++;
    if ({bus.ad_out, bus.dato_leido} !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_data got %h want 0000",
               {bus.ad_out, bus.dato_leido});
    end
    n_cmp++;
    if ({bus.ocupado, bus.listo, bus.err_ocupado} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 000",
               {bus.ocupado, bus.listo, bus.err_ocupado});
    end
    @(negedge reloj);
    resetM = 1'b1;
    @(negedge reloj);
  endtask

  task automatic test_read();
    int wr_lo = 0, rd_lo = 0, bad_a = 0, bad_oe = 0;
    int first_wr = 0, first_rd = 0, listo_j = 0, nlisto = 0;
    logic ocu1 = 1'b0, cs1 = 1'b1, ocu26 = 1'b1;
    bus.ad_in = 8'h45;
    kick(2'b01, 8'h21, 8'hAA);
    for (int j = 1; j <= 26; j++) begin
      if (j == 1) begin ocu1 = bus.ocupado; cs1 = bus.CS_n; end
      if (j == 26) ocu26 = bus.ocupado;
      if (bus.WR_n == 1'b0) begin
        wr_lo++;
        if (first_wr == 0) first_wr = j;
        if (bus.ad_out !== 8'h21 || bus.A_D !== 1'b0) bad_a++;
      end
      if (bus.RD_n == 1'b0) begin
        rd_lo++;
        if (first_rd == 0) first_rd = j;
        if (bus.ad_oe !== 1'b0 || bus.A_D !== 1'b1) bad_oe++;
      end
      if (bus.listo == 1'b1) begin nlisto++; listo_j = j; end
      @(negedge reloj);
    end
    n_cmp++;
    if ({ocu1, cs1} !== 2'b10) begin
      n_bad++;
      $display("FAIL rd_start got ocu/cs=%b want 10", {ocu1, cs1});
    end
    n_cmp++;
    if (wr_lo != 8 || first_wr != 3 || bad_a != 0) begin
      n_bad++;
      $display("FAIL rd_addr_phase got low=%0d first=%0d bad=%0d want 8 3 0",
               wr_lo, first_wr, bad_a);
    end
    n_cmp++;
    if (rd_lo != 8 || first_rd != 15 || bad_oe != 0) begin
      n_bad++;
      $display("FAIL rd_data_phase got low=%0d first=%0d bad=%0d want 8 15 0",
               rd_lo, first_rd, bad_oe);
    end
    n_cmp++;
    if (listo_j != 25 || nlisto != 1) begin
      n_bad++;
      $display("FAIL rd_listo got at=%0d n=%0d want 25 1", listo_j, nlisto);
    end
    n_cmp++;
    if (ocu26 !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_ocupado_end got %b want 0", ocu26);
    end
    n_cmp++;
    if (bus.dato_leido !== 8'h45) begin
      n_bad++;
      $display("FAIL rd_dato got %h want 45", bus.dato_leido);
    end
  endtask

  task automatic test_write();
    int wa_lo = 0, wd_lo = 0, rd_lo = 0, bad_a = 0, bad_d = 0;
    int listo_j = 0;
    bus.ad_in = 8'hEE;
    kick(2'b10, 8'h22, 8'h17);
    for (int j = 1; j <= 26; j++) begin
      if (bus.WR_n == 1'b0 && j <= 12) begin
        wa_lo++;
        if (bus.ad_out !== 8'h22 || bus.A_D !== 1'b0) bad_a++;
      end
      if (bus.WR_n == 1'b0 && j > 12) begin
        wd_lo++;
        if (bus.ad_out !== 8'h17 || bus.A_D !== 1'b1 || bus.ad_oe !== 1'b1)
          bad_d++;
      end
      if (bus.RD_n == 1'b0) rd_lo++;
      if (bus.listo == 1'b1) listo_j = j;
      @(negedge reloj);
    end
    n_cmp++;
    if (wa_lo != 8 || bad_a != 0) begin
      n_bad++;
      $display("FAIL wr_addr_phase got low=%0d bad=%0d want 8 0", wa_lo, bad_a);
    end
    n_cmp++;
    if (wd_lo != 8 || bad_d != 0) begin
      n_bad++;
      $display("FAIL wr_data_phase got low=%0d bad=%0d want 8 0", wd_lo, bad_d);
    end
    n_cmp++;
    if (rd_lo != 0 || listo_j != 25) begin
      n_bad++;
      $display("FAIL wr_rd_listo got rdlow=%0d listo=%0d want 0 25",
               rd_lo, listo_j);
    end
    n_cmp++;
    if (bus.dato_leido !== 8'h45) begin
      n_bad++;
      $display("FAIL wr_dato_hold got %h want 45", bus.dato_leido);
    end
  endtask

  task automatic test_busy();
    int bad_a = 0, rd_lo = 0, wr_dat = 0, listo_j = 0, nerr = 0, err_j = 0;
    bus.ad_in = 8'h45;
    kick(2'b01, 8'h21, 8'h00);
    for (int j = 1; j <= 26; j++) begin
      bus.sync = 1'b0;
      if (j == 5) begin bus.sync = 1'b1; bus.Control = 2'b10; bus.dir = 8'h33; end
      if (j == 12) begin bus.sync = 1'b1; bus.Control = 2'b01; bus.dir = 8'h34; end
      if (j == 18) begin bus.sync = 1'b1; bus.Control = 2'b11; bus.dir = 8'h35; end
      if (j <= 12 && bus.ad_out !== 8'h21) bad_a++;
      if (bus.RD_n == 1'b0) rd_lo++;
      if (j > 12 && bus.WR_n == 1'b0) wr_dat++;
      if (bus.listo == 1'b1) listo_j = j;
      if (bus.err_ocupado == 1'b1) begin
        nerr++;
        if (err_j == 0) err_j = j;
      end
      @(negedge reloj);
    end
    bus.sync = 1'b0;
    n_cmp++;
    if (bad_a != 0 || rd_lo != 8 || wr_dat != 0) begin
      n_bad++;
      $display("FAIL busy_ignored got bad=%0d rdlow=%0d wrdat=%0d want 0 8 0",
               bad_a, rd_lo, wr_dat);
    end
    n_cmp++;
    if (listo_j != 25) begin
      n_bad++;
      $display("FAIL busy_listo got %0d want 25", listo_j);
    end
    n_cmp++;
    if (nerr != EXP_ERR || err_j != EXP_ERR_J) begin
      n_bad++;
      $display("FAIL busy_err got n=%0d at=%0d want %0d %0d",
               nerr, err_j, EXP_ERR, EXP_ERR_J);
    end
  endtask

  task automatic test_invalid();
    int busy = 0;
    kick(2'b11, 8'h40, 8'h00);
    for (int j = 1; j <= 3; j++) begin
      if (bus.ocupado !== 1'b0 || bus.CS_n !== 1'b1) busy++;
      @(negedge reloj);
    end
    kick(2'b00, 8'h41, 8'h00);
    for (int j = 1; j <= 3; j++) begin
      if (bus.ocupado !== 1'b0 || bus.CS_n !== 1'b1) busy++;
      @(negedge reloj);
    end
    n_cmp++;
    if (busy != 0) begin
      n_bad++;
      $display("FAIL invalid_cmd got busy_cycles=%0d want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int nlisto = 0, listo_j = 0;
    bus.ad_in = 8'h99;
    kick(2'b01, 8'h21, 8'h00);
    repeat (16) @(negedge reloj);
    resetM = 1'b0;
    #1;
    n_cmp++;
    if ({bus.CS_n, bus.RD_n, bus.WR_n, bus.A_D, bus.ad_oe} !== 5'b11100) begin
      n_bad++;
      $display("FAIL rstmid_strobes got %b want 11100",
               {bus.CS_n, bus.RD_n, bus.WR_n, bus.A_D, bus.ad_oe});
    end
    n_cmp++;
    if ({bus.ad_out, bus.dato_leido, 6'b0, bus.ocupado, bus.listo} !== 24'h0) begin
      n_bad++;
      $display("FAIL rstmid_data got out=%h leido=%h ocu=%b listo=%b want 0",
               bus.ad_out, bus.dato_leido, bus.ocupado, bus.listo);
    end
    for (int j = 0; j < 12; j++) begin
      if (j == 3) resetM = 1'b1;
      @(negedge reloj);
      if (bus.listo == 1'b1) nlisto++;
    end
    n_cmp++;
    if (nlisto != 0) begin
      n_bad++;
      $display("FAIL rstmid_no_listo got %0d want 0", nlisto);
    end
    bus.ad_in = 8'h5A;
    kick(2'b01, 8'h23, 8'h00);
    for (int j = 1; j <= 26; j++) begin
      if (bus.listo == 1'b1) listo_j = j;
      @(negedge reloj);
    end
    n_cmp++;
    if (listo_j != 25 || bus.dato_leido !== 8'h5A) begin
      n_bad++;
      $display("FAIL rstmid_recover got listo=%0d dato=%h want 25 5a",
               listo_j, bus.dato_leido);
    end
  endtask

  task automatic test_back_to_back();
    int l1 = 0, l2 = 0, nlisto = 0;
    logic ocu26 = 1'b1, ocu27 = 1'b0;
    bus.ad_in = 8'h66;
    kick(2'b01, 8'h24, 8'h00);
    for (int j = 1; j <= 60; j++) begin
      bus.sync = 1'b0;
      if (j == 26) begin
        ocu26 = bus.ocupado;
        bus.sync = 1'b1;
        bus.Control = 2'b10;
        bus.dir = 8'h25;
        bus.dato_esc = 8'h77;
      end
      if (j == 27) ocu27 = bus.ocupado;
      if (bus.listo == 1'b1) begin
        nlisto++;
        if (l1 == 0) l1 = j;
        else l2 = j;
      end
      @(negedge reloj);
    end
    bus.sync = 1'b0;
    n_cmp++;
    if ({ocu26, ocu27} !== 2'b01) begin
      n_bad++;
      $display("FAIL b2b_accept got ocu26/27=%b want 01", {ocu26, ocu27});
    end
    n_cmp++;
    if (nlisto != 2 || l1 != 25 || l2 - l1 != 26) begin
      n_bad++;
      $display("FAIL b2b_spacing got n=%0d first=%0d gap=%0d want 2 25 26",
               nlisto, l1, l2 - l1);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_busy();
    test_invalid();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ciclo_bus_rtc.md
# ciclo_bus_rtc

- Bus-cycle generator downstream of `Maq_Control_General`.
- Takes a one-cycle `sync` start strobe plus the 2-bit `Control` command and runs one complete read or write transaction on the multiplexed address/data bus of the external RTC.
- Each transaction is an address phase followed by a data phase.
- Provides read data and a completion pulse to the rest of the design.

## Interface

Parameters:
- T_SET, 2, cycles of setup in each phase before the strobe asserts (>=1)
- T_PULSO, 8, cycles the WR_n/RD_n strobe is held low in each phase (>=1)
- T_HOLD, 2, cycles after strobe release before the phase ends (>=1)

Ports (clock is `reloj`; reset is `resetM`, asynchronous, active-low):
- reloj  in  1  system clock, rising edge
- resetM  in  1  asynchronous active-low reset
- sync  in  1  start strobe, one cycle, from control FSM
- Control  in  2  command: 00 idle, 01 read, 10 write, 11 reserved
- dir  in  8  RTC register address, sampled with sync
- dato_esc  in  8  write data, sampled with sync
- ad_in  in  8  bus value driven by RTC during reads
- ad_out  out  8  bus value driven by this block
- ad_oe  out  1  1 = this block drives the bus
- CS_n  out  1  chip select, active-low
- RD_n  out  1  read strobe, active-low
- WR_n  out  1  write strobe, active-low
- A_D  out  1  0 = address phase, 1 = data phase
- dato_leido  out  8  last read data, registered
- ocupado  out  1  transaction in progress
- listo  out  1  one-cycle completion pulse
- err_ocupado  out  1  see Configuration

## Operation

- States: IDLE, DIR_SET, DIR_PULSO, DIR_HOLD, DAT_SET, DAT_PULSO, DAT_HOLD, FIN. One shared down-counter times the states.
- **IDLE.** Start requires `sync=1` with `Control` equal to 01 or 10. On start:
  - latch `Control`, `dir` and `dato_esc`;
  - go to DIR_SET.
  - `sync` with `Control` equal to 00 or 11 is ignored.
- **Address phase (DIR_\*).**
  - CS_n=0, A_D=0, ad_oe=1, ad_out=latched dir.
  - WR_n=0 only during DIR_PULSO, for both reads and writes.
- **Data phase (DAT_\*).**
  - CS_n=0, A_D=1.
  - Write: ad_oe=1, ad_out=latched dato_esc, WR_n=0 during DAT_PULSO.
  - Read: ad_oe=0, RD_n=0 during DAT_PULSO. `dato_leido` loads `ad_in` on the last DAT_PULSO cycle.
- **FIN.** All strobes inactive and listo=1 for one cycle, then return to IDLE.
- `ocupado` is 1 in every state except IDLE.
- `sync` arriving while ocupado=1 is ignored, and latched values do not change.
- `dato_leido` holds its value across writes and idle periods.

## Timing

- Reset values:
  - CS_n=RD_n=WR_n=1, A_D=0, ad_oe=0, ad_out=00;
  - dato_leido=00, ocupado=0, listo=0, err_ocupado=0;
  - state IDLE.
- All outputs are registered, so nothing combinational runs from inputs to outputs.
- `sync` sampled high at edge k: ocupado=1 and CS_n=0 from edge k+1.
- Each phase lasts T_SET+T_PULSO+T_HOLD cycles.
- listo is high at cycle k+1+2·(T_SET+T_PULSO+T_HOLD). With defaults that is k+25; ocupado=0 from k+26.
- A new `sync` is accepted in the cycle in which ocupado=0 again. The block never re-accepts during FIN.
- A_D and ad_out are stable throughout every strobe-low interval; they change only in SET states.
- Reset asserted mid-transaction:
  - strobes and CS_n go inactive immediately and asynchronously;
  - ad_oe goes to 0;
  - no listo is produced;
  - dato_leido clears to 00.

## Configuration

- Macro `RTC_BUS_ERR_EN`.
- Defined: `err_ocupado` pulses 1 for one cycle, one cycle after a `sync` with `Control` equal to 01 or 10 is sampled while ocupado=1. The request is still ignored.
- Undefined: `err_ocupado` is constant 0 and the detection logic is absent.

## Test plan

- **Read.** Reset, then `sync` with Control=01, dir=21, ad_in=45.
  - Address phase drives ad_out=21 with WR_n low for 8 cycles.
  - Data phase has ad_oe=0 and RD_n low for 8 cycles.
  - listo at k+25; dato_leido=45.
- **Write.** `sync` with Control=10, dir=22, dato_esc=17.
  - ad_out=22, then ad_out=17 with A_D=1 and WR_n low for 8 cycles.
  - RD_n stays 1 throughout; dato_leido is unchanged.
- **Busy / invalid command.**
  - `sync` with Control=10, dir=33 at k+5 during a read: ignored, ad_out stays at the original address.
  - `sync` with Control=11 in IDLE: ocupado stays 0.
- **Reset mid-operation.** resetM=0 during DAT_PULSO of a read: all outputs are at reset values before the next edge, with no listo. After release, a new read completes normally.
- **Back-to-back.** Second `sync` in the first cycle with ocupado=0 is accepted; two listo pulses are exactly 26 cycles apart.
- **With RTC_BUS_ERR_EN.** `sync` with Control=01 during a transaction: err_ocupado=1 for exactly one cycle. Without the macro, err_ocupado stays 0.
